lcd_bus_receiver: RTL

LCD_BUS_RECEIVER -- requirements
Module: lcd_bus_receiver

---
 rtl/lcd_bus_receiver.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_bus_receiver.sv
// Receiver for an 8080-style LCD write bus: synchronizes the asynchronous
// strobe/data lines, decodes window-setup commands (CASET/PASET), and
// converts RAMWR byte pairs into RGB pixels with window-wrapping coordinates.
module lcd_bus_receiver #(
  parameter int H_MAX = 320,
  parameter int V_MAX = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] lcd_db,
  input  logic       lcd_wr,
  input  logic       lcd_d_c,
  input  logic       lcd_reset,
  output logic       pix_valid,
  output logic [8:0] pix_x,
  output logic [8:0] pix_y,
  output logic [3:0] pix_r,
  output logic [3:0] pix_g,
  output logic [3:0] pix_b,
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic       cfg_err
);

  localparam logic [8:0] X_LAST = 9'(H_MAX - 1);
  localparam logic [8:0] Y_LAST = 9'(V_MAX - 1);

  typedef enum logic [2:0] {
    IDLE,
    CASET,
    PASET,
    RAMWR_HI,
    RAMWR_LO
  } state_t;

  // Clamp a 16-bit panel coordinate to the last legal index.
  function automatic logic [8:0] sat_coord(input logic [15:0] v, input logic [8:0] lim);
    return (v > {7'd0, lim}) ? lim : v[8:0];
  endfunction

  // Synchronizer flops; the strobe idles high so reset parks it there.
  logic [7:0] db_meta, db_sync;
  logic       dc_meta, dc_sync;
  logic       wr_meta, wr_sync, wr_prev;
  logic       nrst_meta, nrst_sync;

  // Registered write event (stage p0) with the byte it carries.
  logic       vld_p0;
  logic [7:0] db_p0;
  logic       dc_p0;

  // Decoder state.
  state_t     state, state_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic [7:0] par_hi, par_hi_nxt;
  logic [8:0] start_tmp, start_tmp_nxt;
  logic [8:0] sc, sc_nxt, ec, ec_nxt, sp, sp_nxt, ep, ep_nxt;
  logic [8:0] cur_x, cur_x_nxt, cur_y, cur_y_nxt;
  logic [7:0] px_hi, px_hi_nxt;

  // Output next values.
  logic       pix_valid_nxt, cmd_valid_nxt, cfg_err_nxt;
  logic [8:0] pix_x_nxt, pix_y_nxt;
  logic [3:0] pix_r_nxt, pix_g_nxt, pix_b_nxt;
  logic [7:0] cmd_code_nxt;

  logic       wr_event;
  logic       soft_rst;
  logic [8:0] par_sat;

  assign wr_event = wr_sync & ~wr_prev;
  assign soft_rst = ~nrst_sync;

  // Data-side synchronizer and event payload capture (no reset needed).
  always_ff @(posedge clk) begin
    db_meta <= lcd_db;
    db_sync <= db_meta;
    dc_meta <= lcd_d_c;
    dc_sync <= dc_meta;
    db_p0   <= db_sync;
    dc_p0   <= dc_sync;
  end

  // Control-side synchronizers, strobe edge detect and event valid (stage p0).
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_meta   <= 1'b1;
      wr_sync   <= 1'b1;
      wr_prev   <= 1'b1;
      nrst_meta <= 1'b1;
      nrst_sync <= 1'b1;
      vld_p0    <= 1'b0;
    end else begin
      wr_meta   <= lcd_wr;
      wr_sync   <= wr_meta;
      wr_prev   <= wr_sync;
      nrst_meta <= lcd_reset;
      nrst_sync <= nrst_meta;
      vld_p0    <= wr_event & nrst_sync;
    end
  end

  // Next-state and output decode for one received byte.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    par_hi_nxt    = par_hi;
    start_tmp_nxt = start_tmp;
    sc_nxt        = sc;
    ec_nxt        = ec;
    sp_nxt        = sp;
    ep_nxt        = ep;
    cur_x_nxt     = cur_x;
    cur_y_nxt     = cur_y;
    px_hi_nxt     = px_hi;
    pix_valid_nxt = 1'b0;
    cmd_valid_nxt = 1'b0;
    cfg_err_nxt   = 1'b0;
    pix_x_nxt     = pix_x;
    pix_y_nxt     = pix_y;
    pix_r_nxt     = pix_r;
    pix_g_nxt     = pix_g;
    pix_b_nxt     = pix_b;
    cmd_code_nxt  = cmd_code;
    par_sat       = sat_coord({par_hi, db_p0}, (state == CASET) ? X_LAST : Y_LAST);

    if (soft_rst) begin
      // Panel reset: clear decoder and window, leave visible outputs alone.
      state_nxt = IDLE;
      cnt_nxt   = 2'd0;
      sc_nxt    = 9'd0;
      ec_nxt    = X_LAST;
      sp_nxt    = 9'd0;
      ep_nxt    = Y_LAST;
      cur_x_nxt = 9'd0;
      cur_y_nxt = 9'd0;
    end else if (vld_p0) begin
      if (!dc_p0) begin
        // Any command aborts the current transaction, including a lone high byte.
        cmd_valid_nxt = 1'b1;
        cmd_code_nxt  = db_p0;
        cnt_nxt       = 2'd0;
        case (db_p0)
          8'h2A:   state_nxt = CASET;
          8'h2B:   state_nxt = PASET;
          8'h2C: begin
            state_nxt = RAMWR_HI;
            cur_x_nxt = sc;
            cur_y_nxt = sp;
          end
          8'h01: begin
            state_nxt = IDLE;
            sc_nxt    = 9'd0;
            ec_nxt    = X_LAST;
            sp_nxt    = 9'd0;
            ep_nxt    = Y_LAST;
          end
          default: state_nxt = IDLE;
        endcase
      end else begin
        case (state)
          CASET, PASET: begin
            cnt_nxt = cnt + 2'd1;
            case (cnt)
              2'd1:    start_tmp_nxt = par_sat;
              2'd3: begin
                state_nxt = IDLE;
                if (start_tmp > par_sat) begin
                  cfg_err_nxt = 1'b1;
                end else if (state == CASET) begin
                  sc_nxt = start_tmp;
                  ec_nxt = par_sat;
                end else begin
                  sp_nxt = start_tmp;
                  ep_nxt = par_sat;
                end
              end
              default: par_hi_nxt = db_p0;
            endcase
          end
          RAMWR_HI: begin
            px_hi_nxt = db_p0;
            state_nxt = RAMWR_LO;
          end
          RAMWR_LO: begin
            pix_valid_nxt = 1'b1;
            pix_x_nxt     = cur_x;
            pix_y_nxt     = cur_y;
            pix_r_nxt     = px_hi[7:4];
            pix_g_nxt     = {px_hi[2:0], db_p0[7]};
            pix_b_nxt     = db_p0[4:1];
            state_nxt     = RAMWR_HI;
            if (cur_x >= ec) begin
              cur_x_nxt = sc;
              cur_y_nxt = (cur_y >= ep) ? sp : cur_y + 9'd1;
            end else begin
              cur_x_nxt = cur_x + 9'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Decoder and output registers (stage p1).
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      par_hi    <= 8'd0;
      start_tmp <= 9'd0;
      sc        <= 9'd0;
      ec        <= X_LAST;
      sp        <= 9'd0;
      ep        <= Y_LAST;
      cur_x     <= 9'd0;
      cur_y     <= 9'd0;
      px_hi     <= 8'd0;
      pix_valid <= 1'b0;
      cmd_valid <= 1'b0;
      cfg_err   <= 1'b0;
      pix_x     <= 9'd0;
      pix_y     <= 9'd0;
      pix_r     <= 4'd0;
      pix_g     <= 4'd0;
      pix_b     <= 4'd0;
      cmd_code  <= 8'd0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      par_hi    <= par_hi_nxt;
      start_tmp <= start_tmp_nxt;
      sc        <= sc_nxt;
      ec        <= ec_nxt;
      sp        <= sp_nxt;
      ep        <= ep_nxt;
      cur_x     <= cur_x_nxt;
      cur_y     <= cur_y_nxt;
      px_hi     <= px_hi_nxt;
      pix_valid <= pix_valid_nxt;
      cmd_valid <= cmd_valid_nxt;
      cfg_err   <= cfg_err_nxt;
      pix_x     <= pix_x_nxt;
      pix_y     <= pix_y_nxt;
      pix_r     <= pix_r_nxt;
      pix_g     <= pix_g_nxt;
      pix_b     <= pix_b_nxt;
      cmd_code  <= cmd_code_nxt;
    end
  end

endmodule
